// File: rtl/xor5_parity_checker.sv
// xor5_parity_checker
//   Receiving end of the XOR parity path. Takes a serial frame of DATA_BITS
//   data bits (LSB first) followed by one parity bit over a valid/ready
//   stream. It reassembles the data word, recomputes the XOR parity and
//   flags a mismatch on a registered valid/ready result port.
//
// Parameters
//   DATA_BITS   data bits per frame (>=2); the parity bit follows them
//   PARITY_ODD  0: even parity (XOR over data+parity must be 0)
//               1: odd parity  (XOR over data+parity must be 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_bit is valid
//   in_ready   checker accepts in_bit this cycle (low while a result is held)
//   in_bit     serial bit: data LSB first, then parity
//   out_valid  frame result valid
//   out_ready  downstream accepts the result
//   out_data   reassembled data word (first received bit -> out_data[0])
//   out_err    1 = parity mismatch on this frame
//   err_cnt    saturating count of errored frames
//
// Configuration macro
//   XOR5_PARITY_CHECKER_ERR_CNT_EN  defined: err_cnt counts output transfers
//                                   with out_err=1, saturating at 8'hFF.
//                                   undefined: err_cnt is tied to 8'h00.

module xor5_parity_checker #(
  parameter int unsigned DATA_BITS  = 5,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_err,
  output logic [7:0]           err_cnt
);

  localparam int unsigned CW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    PAR  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 acc;
  logic                 in_xfer;
  logic                 out_xfer;

  // Pure decode of the state register, so in_ready never depends on in_valid.
  assign in_ready = (state != HOLD);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RECV;
      cnt       <= '0;
      shift     <= '0;
      acc       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (in_xfer) begin
            shift[cnt] <= in_bit;
            acc        <= acc ^ in_bit;
            if (cnt == CW'(DATA_BITS - 1)) begin
              cnt   <= '0;
              state <= PAR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PAR: begin
          // The accepted bit is the parity bit; the result is registered
          // on the same edge so out_valid rises one cycle after it.
          if (in_xfer) begin
            out_data  <= shift;
            out_err   <= ((acc ^ in_bit) != PARITY_ODD);
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            acc       <= 1'b0;
            shift     <= '0;
            state     <= RECV;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

`ifdef XOR5_PARITY_CHECKER_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (out_xfer && out_err && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_xor5_parity_checker.sv
// Bench for xor5_parity_checker. Two instances share one stimulus stream:
// dut0 checks even parity, dut1 checks odd parity, so every frame has a
// known expected error flag for each. Expected results are pushed to a
// scoreboard queue when the parity bit is sent and popped when the result
// appears.

module tb_xor5_parity_checker;

`ifdef XOR5_PARITY_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0] d;
    logic       e0;
    logic       e1;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       in_ready0, out_valid0, out_err0;
  logic       in_ready1, out_valid1, out_err1;
  logic [4:0] out_data0, out_data1;
  logic [7:0] err_cnt0, err_cnt1;

  exp_t       sb[$];
  logic [7:0] exp_cnt0;
  logic [7:0] exp_cnt1;
  int unsigned n_pass;
  int unsigned n_total;

  xor5_parity_checker #(.DATA_BITS(5), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_bit(in_bit), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_err(out_err0), .err_cnt(err_cnt0)
  );

  xor5_parity_checker #(.DATA_BITS(5), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_bit(in_bit), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_err(out_err1), .err_cnt(err_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // All stimulus and sampling happen on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Sends data (LSB first) and parity, with up to maxgap idle cycles before
  // each bit, and pushes the expected result. Returns on the falling edge
  // just after the parity-bit transfer.
  task automatic send_frame(input logic [4:0] d, input logic p, input int unsigned maxgap);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
      if (i < 5) send_bit(d[i]);
      else       send_bit(p);
    end
    e.d  = d;
    e.e0 = ^{d, p};
    e.e1 = ~^{d, p};
    sb.push_back(e);
  endtask

  // Completes the output transfer and advances the error-count model.
  task automatic take(input exp_t e);
    out_ready = 1'b1;
    tick();
    if (CNT_EN) begin
      if (e.e0 && exp_cnt0 != 8'hFF) exp_cnt0 = exp_cnt0 + 8'd1;
      if (e.e1 && exp_cnt1 != 8'hFF) exp_cnt1 = exp_cnt1 + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    repeat (2) tick();
    n_total++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) $display("FAIL reset_in_ready got=%b%b exp=11", in_ready0, in_ready1); else n_pass++;
    n_total++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) $display("FAIL reset_out_valid got=%b%b exp=00", out_valid0, out_valid1); else n_pass++;
    n_total++; if (out_data0 !== 5'd0 || out_err0 !== 1'b0) $display("FAIL reset_out_data got=%b/%b exp=00000/0", out_data0, out_err0); else n_pass++;
    n_total++; if (err_cnt0 !== 8'h00 || err_cnt1 !== 8'h00) $display("FAIL reset_err_cnt got=%h/%h exp=00/00", err_cnt0, err_cnt1); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    exp_t e;
    out_ready = 1'b1;
    send_frame(5'b01101, 1'b1, 0);
    n_total++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) $display("FAIL good_latency got=%b%b exp=11", out_valid0, out_valid1); else n_pass++;
    e = sb.pop_front();
    n_total++; if (out_data0 !== e.d || out_data1 !== e.d) $display("FAIL good_data got=%b/%b exp=%b", out_data0, out_data1, e.d); else n_pass++;
    n_total++; if (out_err0 !== e.e0 || out_err1 !== e.e1) $display("FAIL good_err got=%b%b exp=%b%b", out_err0, out_err1, e.e0, e.e1); else n_pass++;
    take(e);
    n_total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL good_release got v=%b r=%b exp v=0 r=1", out_valid0, in_ready0); else n_pass++;
    n_total++; if (err_cnt0 !== exp_cnt0 || err_cnt1 !== exp_cnt1) $display("FAIL good_err_cnt got=%h/%h exp=%h/%h", err_cnt0, err_cnt1, exp_cnt0, exp_cnt1); else n_pass++;
  endtask

  task automatic test_bad_frame();
    exp_t e;
    out_ready = 1'b0;
    send_frame(5'b01101, 1'b0, 0);
    e = sb.pop_front();
    n_total++; if (out_valid0 !== 1'b1 || out_data0 !== e.d) $display("FAIL bad_data got v=%b d=%b exp v=1 d=%b", out_valid0, out_data0, e.d); else n_pass++;
    n_total++; if (out_err0 !== e.e0 || out_err1 !== e.e1) $display("FAIL bad_err got=%b%b exp=%b%b", out_err0, out_err1, e.e0, e.e1); else n_pass++;
    n_total++; if (err_cnt0 !== exp_cnt0) $display("FAIL bad_err_cnt_before got=%h exp=%h", err_cnt0, exp_cnt0); else n_pass++;
    take(e);
    n_total++; if (err_cnt0 !== exp_cnt0 || err_cnt1 !== exp_cnt1) $display("FAIL bad_err_cnt_after got=%h/%h exp=%h/%h", err_cnt0, err_cnt1, exp_cnt0, exp_cnt1); else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    send_frame(5'b11010, 1'b0, 0);
    e = sb.pop_front();
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_total++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) $display("FAIL bp_hold_%0d got r=%b v=%b exp r=0 v=1", c, in_ready0, out_valid0); else n_pass++;
      n_total++; if (out_data0 !== e.d || out_err0 !== e.e0 || out_err1 !== e.e1) $display("FAIL bp_stable_%0d got=%b/%b%b exp=%b/%b%b", c, out_data0, out_err0, out_err1, e.d, e.e0, e.e1); else n_pass++;
    end
    in_valid = 1'b0;
    take(e);
    n_total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid0, in_ready0); else n_pass++;
    n_total++; if (err_cnt0 !== exp_cnt0 || err_cnt1 !== exp_cnt1) $display("FAIL bp_err_cnt got=%h/%h exp=%h/%h", err_cnt0, err_cnt1, exp_cnt0, exp_cnt1); else n_pass++;
  endtask

  task automatic test_gaps();
    exp_t e;
    logic [4:0] d;
    logic p;
    out_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      d = (f == 0) ? 5'b01101 : 5'($urandom_range(0, 31));
      p = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(d, p, 3);
      e = sb.pop_front();
      n_total++; if (out_valid0 !== 1'b1 || out_data0 !== e.d || out_data1 !== e.d) $display("FAIL gaps_%0d_data got v=%b d=%b/%b exp=%b", f, out_valid0, out_data0, out_data1, e.d); else n_pass++;
      n_total++; if (out_err0 !== e.e0 || out_err1 !== e.e1) $display("FAIL gaps_%0d_err got=%b%b exp=%b%b", f, out_err0, out_err1, e.e0, e.e1); else n_pass++;
      take(e);
    end
    n_total++; if (err_cnt0 !== exp_cnt0 || err_cnt1 !== exp_cnt1) $display("FAIL gaps_err_cnt got=%h/%h exp=%h/%h", err_cnt0, err_cnt1, exp_cnt0, exp_cnt1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send_frame(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0);
      e = sb.pop_front();
      n_total++; if (out_data0 !== e.d || out_err0 !== e.e0 || out_err1 !== e.e1) $display("FAIL b2b_%0d got=%b/%b%b exp=%b/%b%b", f, out_data0, out_err0, out_err1, e.d, e.e0, e.e1); else n_pass++;
      take(e);
    end
  endtask

  task automatic test_parity_odd();
    exp_t e;
    out_ready = 1'b1;
    send_frame(5'b00000, 1'b1, 0);
    e = sb.pop_front();
    n_total++; if (out_valid1 !== 1'b1 || out_data1 !== 5'b00000) $display("FAIL odd_data got v=%b d=%b exp v=1 d=00000", out_valid1, out_data1); else n_pass++;
    n_total++; if (out_err1 !== e.e1 || out_err0 !== e.e0) $display("FAIL odd_err got odd=%b even=%b exp odd=%b even=%b", out_err1, out_err0, e.e1, e.e0); else n_pass++;
    take(e);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Reset while a result is held.
    out_ready = 1'b0;
    send_frame(5'b10110, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) $display("FAIL rst_hold got r=%b v=%b exp r=1 v=0", in_ready0, out_valid0); else n_pass++;
    n_total++; if (err_cnt0 !== 8'h00 || err_cnt1 !== 8'h00) $display("FAIL rst_hold_err_cnt got=%h/%h exp=00/00", err_cnt0, err_cnt1); else n_pass++;
    sb.delete();
    exp_cnt0 = '0; exp_cnt1 = '0;
    tick();
    rst_n = 1'b1;
    tick();
    // Reset part-way through a frame.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || err_cnt0 !== 8'h00) $display("FAIL rst_mid got r=%b v=%b c=%h exp r=1 v=0 c=00", in_ready0, out_valid0, err_cnt0); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_frame(5'b00100, 1'b1, 0);
    e = sb.pop_front();
    n_total++; if (out_valid0 !== 1'b1 || out_data0 !== e.d || out_err0 !== e.e0) $display("FAIL rst_mid_frame got v=%b d=%b e=%b exp v=1 d=%b e=%b", out_valid0, out_data0, out_err0, e.d, e.e0); else n_pass++;
    take(e);
  endtask

  task automatic test_saturation();
    exp_t e;
    int unsigned bad;
    out_ready = 1'b1;
    bad = 0;
    // Parity 0 over all-zero data: good for dut0, bad for dut1.
    for (int f = 0; f < 260; f++) begin
      send_frame(5'b00000, 1'b0, 0);
      e = sb.pop_front();
      if (out_err1 !== e.e1 || out_err0 !== e.e0) bad++;
      take(e);
    end
    n_total++; if (bad != 0) $display("FAIL sat_frames got=%0d wrong flags exp=0", bad); else n_pass++;
    n_total++; if (err_cnt1 !== exp_cnt1) $display("FAIL sat_err_cnt_odd got=%h exp=%h", err_cnt1, exp_cnt1); else n_pass++;
    n_total++; if (err_cnt0 !== exp_cnt0) $display("FAIL sat_err_cnt_even got=%h exp=%h", err_cnt0, exp_cnt0); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_parity_odd();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
